// File: rtl/tsq_arb_if.sv
// Bundle of queue read ports, the timestamp output stream and drain counters
// seen by the timestamp-queue arbiter.
interface tsq_arb_if #(
  parameter int CNT_W = 16
);
  logic             enable_in;
  logic [7:0]       rx_q_stat_in;
  logic [63:0]      rx_q_data_in;
  logic             rx_q_rd_en_out;
  logic [7:0]       tx_q_stat_in;
  logic [63:0]      tx_q_data_in;
  logic             tx_q_rd_en_out;
  logic             ts_valid_out;
  logic             ts_ready_in;
  logic             ts_src_out;
  logic [63:0]      ts_data_out;
  logic             cnt_clr_in;
  logic [CNT_W-1:0] rx_cnt_out;
  logic [CNT_W-1:0] tx_cnt_out;

  modport master (
    input  enable_in, rx_q_stat_in, rx_q_data_in, tx_q_stat_in, tx_q_data_in,
           ts_ready_in, cnt_clr_in,
    output rx_q_rd_en_out, tx_q_rd_en_out, ts_valid_out, ts_src_out,
           ts_data_out, rx_cnt_out, tx_cnt_out
  );

  modport slave (
    output enable_in, rx_q_stat_in, rx_q_data_in, tx_q_stat_in, tx_q_data_in,
           ts_ready_in, cnt_clr_in,
    input  rx_q_rd_en_out, tx_q_rd_en_out, ts_valid_out, ts_src_out,
           ts_data_out, rx_cnt_out, tx_cnt_out
  );
endinterface

// File: rtl/tsq_arb.sv
// Round-robin drain of the RX/TX timestamp queues onto one valid/ready stream,
// with saturating per-source delivery counters.
module tsq_arb #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic      clk,
  input  logic      rst,
  tsq_arb_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_WAIT, S_OUT} state_t;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_src_q, last_src_d;
  logic [1:0]  lat_q, lat_d;
  logic        valid_q, valid_d;
  logic        src_q, src_d;
  logic [63:0] data_q, data_d;

  logic rx_el, tx_el, pick, hs;

  assign rx_el = bus.enable_in && (bus.rx_q_stat_in != 8'd0);
  assign tx_el = bus.enable_in && (bus.tx_q_stat_in != 8'd0);
  // Tie goes to the source that did not win last; a lone requester always wins.
  assign pick  = (rx_el && tx_el) ? ~last_src_q : tx_el;
  assign hs    = valid_q && bus.ts_ready_in;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_src_d = last_src_q;
    lat_d      = lat_q;
    valid_d    = valid_q;
    src_d      = src_q;
    data_d     = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_el || tx_el) begin
          grant_d    = pick;
          last_src_d = pick;
          state_d    = S_POP;
        end
      end
      S_POP: begin
        lat_d   = 2'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          valid_d = 1'b1;
          src_d   = grant_q;
          data_d  = grant_q ? bus.tx_q_data_in : bus.rx_q_data_in;
          state_d = S_OUT;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_OUT: begin
        if (bus.ts_ready_in) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= 1'b0;
      last_src_q <= 1'b1;
      lat_q      <= 2'd0;
      valid_q    <= 1'b0;
      src_q      <= 1'b0;
      data_q     <= 64'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_src_q <= last_src_d;
      lat_q      <= lat_d;
      valid_q    <= valid_d;
      src_q      <= src_d;
      data_q     <= data_d;
    end
  end

  assign bus.rx_q_rd_en_out = (state_q == S_POP) && !grant_q;
  assign bus.tx_q_rd_en_out = (state_q == S_POP) &&  grant_q;
  assign bus.ts_valid_out   = valid_q;
  assign bus.ts_src_out     = src_q;
  assign bus.ts_data_out    = data_q;

  // Index 0 counts RX deliveries, index 1 counts TX; clear beats increment.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic             inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign inc = hs && (grant_q == 1'(gi));

    always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clr_in) begin
        cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    if (gi == 0) begin : g_rx
      assign bus.rx_cnt_out = cnt_q;
    end else begin : g_tx
      assign bus.tx_cnt_out = cnt_q;
    end
  end

endmodule
